// File: rtl/cache_dm_ctrl.sv
// cache_dm_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//
// The core issues single-word read/write pulses and receives one-cycle fin pulses.
// The memory side moves whole 128-bit lines over a req/ack handshake.
// The byte address is split as {tag, index, offset}, with 4 words per line.
//
// Ports
//   clk, rstn             clock (rising edge), synchronous active-low reset
//   core2cache_rd_*       read request pulse and byte address
//   core2cache_wr_*       write request pulse, byte address and data word
//   cache2core_rd_fin     one-cycle read-done pulse; rd_data is valid with it
//   cache2core_wr_fin     one-cycle write-done pulse
//   cache2core_rd_data    last read word, held until the next read completes
//   busy                  high whenever the controller is not idle
//   mem_req/we/addr/wdata line transfer request, held stable until mem_ack
//   mem_ack/rdata         one-cycle completion pulse and fill line
module cache_dm_ctrl #(
  parameter int unsigned TAG_W    = 13,
  parameter int unsigned INDEX_W  = 10,
  parameter int unsigned OFFSET_W = 4
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        core2cache_rd_en,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] core2cache_rd_addr,
  input  logic                        core2cache_wr_en,
  input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] core2cache_wr_addr,
  input  logic [31:0]                 core2cache_wr_data,
  output logic                        cache2core_rd_fin,
  output logic                        cache2core_wr_fin,
  output logic [31:0]                 cache2core_rd_data,
  output logic                        busy,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [TAG_W+INDEX_W-1:0]    mem_addr,
  output logic [127:0]                mem_wdata,
  input  logic                        mem_ack,
  input  logic [127:0]                mem_rdata
);

  localparam int unsigned AddrW = TAG_W + INDEX_W + OFFSET_W;
  localparam int unsigned Lines = 1 << INDEX_W;

  localparam logic [2:0] StInit   = 3'd0;
  localparam logic [2:0] StIdle   = 3'd1;
  localparam logic [2:0] StLookup = 3'd2;
  localparam logic [2:0] StWb     = 3'd3;
  localparam logic [2:0] StFill   = 3'd4;
  localparam logic [2:0] StResp   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [INDEX_W-1:0] init_idx_q, init_idx_d;
  logic               req_we_q, req_we_d;
  logic [AddrW-1:0]   req_addr_q, req_addr_d;
  logic [31:0]        req_wdata_q, req_wdata_d;
  logic               pend_q, pend_d;
  logic [AddrW-1:0]   pend_addr_q, pend_addr_d;
  logic [31:0]        rd_data_q, rd_data_d;
  logic [127:0]       line_q;

  // Per-line metadata and line storage.
  logic               valid_q [Lines];
  logic               dirty_q [Lines];
  logic [TAG_W-1:0]   tag_q   [Lines];
  logic [127:0]       data_ram [Lines];

  // Array write controls.
  logic               meta_we;
  logic [INDEX_W-1:0] meta_idx;
  logic               meta_valid, meta_dirty;
  logic [TAG_W-1:0]   meta_tag;
  logic               data_we;
  logic [127:0]       data_wd;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [1:0]         req_word;
  logic [INDEX_W-1:0] rd_idx_d;
  logic               hit;

  // Byte-within-word address bits carry no information for word accesses.
  logic unused_byte_bits;
  assign unused_byte_bits = ^{core2cache_rd_addr[1:0], core2cache_wr_addr[1:0],
                              req_addr_q[1:0]};

  assign req_tag  = req_addr_q[AddrW-1 -: TAG_W];
  assign req_idx  = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_word = req_addr_q[3:2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  function automatic logic [127:0] merge_word(input logic [127:0] line, input logic [1:0] sel,
                                              input logic [31:0] word);
    logic [127:0] res;
    res = line;
    res[32*sel +: 32] = word;
    return res;
  endfunction

  function automatic logic [31:0] pick_word(input logic [127:0] line, input logic [1:0] sel);
    return line[32*sel +: 32];
  endfunction

  always_comb begin
    state_d     = state_q;
    init_idx_d  = init_idx_q;
    req_we_d    = req_we_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    rd_data_d   = rd_data_q;
    meta_we     = 1'b0;
    meta_idx    = req_idx;
    meta_valid  = 1'b0;
    meta_dirty  = 1'b0;
    meta_tag    = req_tag;
    data_we     = 1'b0;
    data_wd     = mem_rdata;

    unique case (state_q)
      StInit: begin
        meta_we    = 1'b1;
        meta_idx   = init_idx_q;
        meta_tag   = '0;
        init_idx_d = init_idx_q + 1'b1;
        if (init_idx_q == {INDEX_W{1'b1}}) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        // Write wins a same-cycle collision; the read waits as pending.
        if (core2cache_wr_en) begin
          req_we_d    = 1'b1;
          req_addr_d  = core2cache_wr_addr;
          req_wdata_d = core2cache_wr_data;
          if (core2cache_rd_en) begin
            pend_d      = 1'b1;
            pend_addr_d = core2cache_rd_addr;
          end
          state_d = StLookup;
        end else if (core2cache_rd_en) begin
          req_we_d   = 1'b0;
          req_addr_d = core2cache_rd_addr;
          state_d    = StLookup;
        end
      end
      StLookup: begin
        if (hit) begin
          if (req_we_q) begin
            data_we    = 1'b1;
            data_wd    = merge_word(line_q, req_word, req_wdata_q);
            meta_we    = 1'b1;
            meta_valid = 1'b1;
            meta_dirty = 1'b1;
          end else begin
            rd_data_d = pick_word(line_q, req_word);
          end
          state_d = StResp;
        end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
          state_d = StWb;
        end else begin
          state_d = StFill;
        end
      end
      StWb: begin
        if (mem_ack) begin
          state_d = StFill;
        end
      end
      StFill: begin
        if (mem_ack) begin
          data_we    = 1'b1;
          data_wd    = req_we_q ? merge_word(mem_rdata, req_word, req_wdata_q) : mem_rdata;
          meta_we    = 1'b1;
          meta_valid = 1'b1;
          meta_dirty = req_we_q;
          if (!req_we_q) begin
            rd_data_d = pick_word(mem_rdata, req_word);
          end
          state_d = StResp;
        end
      end
      StResp: begin
        if (pend_q) begin
          pend_d     = 1'b0;
          req_we_d   = 1'b0;
          req_addr_d = pend_addr_q;
          state_d    = StLookup;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StInit;
    endcase
  end

  // RAM is read one cycle ahead with the index the next LOOKUP will use; no RAM write
  // happens in IDLE or RESP, so the line captured there is current.
  assign rd_idx_d = req_addr_d[OFFSET_W +: INDEX_W];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StInit;
      init_idx_q  <= '0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_idx_q  <= init_idx_d;
      req_we_q    <= req_we_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      rd_data_q   <= rd_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && meta_we) begin
      valid_q[meta_idx] <= meta_valid;
      dirty_q[meta_idx] <= meta_dirty;
      tag_q[meta_idx]   <= meta_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && data_we) begin
      data_ram[req_idx] <= data_wd;
    end
    line_q <= data_ram[rd_idx_d];
  end

  always_comb begin
    busy               = (state_q != StIdle);
    cache2core_rd_fin  = (state_q == StResp) && !req_we_q;
    cache2core_wr_fin  = (state_q == StResp) && req_we_q;
    cache2core_rd_data = rd_data_q;
    mem_req            = (state_q == StWb) || (state_q == StFill);
    mem_we             = (state_q == StWb);
    mem_addr           = '0;
    mem_wdata          = '0;
    if (state_q == StWb) begin
      mem_addr  = {tag_q[req_idx], req_idx};
      mem_wdata = line_q;
    end else if (state_q == StFill) begin
      mem_addr = {req_tag, req_idx};
    end
  end

endmodule
